rc4_seq_ctrl: RTL and testbench

//  Phase sequencer for the RC4 S-box RAM (`ram`, instantiated by the parent).

---
 rtl/rc4_seq_ctrl_pkg.sv | 30 +++
 rtl/rc4_seq_ctrl_if.sv | 30 +++
 rtl/rc4_seq_ctrl_key_sel.sv | 43 ++++
 rtl/rc4_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_rc4_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_seq_ctrl_pkg.sv
// Shared types and constants for the RC4 S-box phase sequencer.
package rc4_seq_ctrl_pkg;

  localparam int SBOX_DEPTH = 256;
  localparam int ADDR_W     = 8;
  localparam int INIT_CYC   = 256;
  localparam int KSA_CYC    = 3;
  localparam int PRGA_CYC   = 5;

  typedef logic [ADDR_W-1:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_KSA_RDI = 4'd2,
    ST_KSA_RDJ = 4'd3,
    ST_KSA_SWP = 4'd4,
    ST_P_RDI   = 4'd5,
    ST_P_RDJ   = 4'd6,
    ST_P_SWP   = 4'd7,
    ST_P_RDT   = 4'd8,
    ST_P_OUT   = 4'd9
  } state_t;

  // A key length is usable only when it names at least one byte and fits the key bus.
  function automatic logic key_len_legal(input logic [4:0] len, input int max_len);
    return (len != 5'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/rc4_seq_ctrl_if.sv
// S-box RAM ports plus the keystream valid/ready handshake.
interface rc4_seq_ctrl_if;
  import rc4_seq_ctrl_pkg::*;

  byte_t      raddr_1;
  logic [7:0] rdata_1;
  byte_t      waddr_2;
  logic [7:0] wdata_2;
  logic       wen_2;
  byte_t      addr_3;
  logic [7:0] wdata_3;
  logic       wen_3;
  logic [7:0] rdata_3;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;

  modport master (
    output raddr_1, waddr_2, wdata_2, wen_2, addr_3, wdata_3, wen_3,
    output ks_data, ks_valid,
    input  rdata_1, rdata_3, ks_ready
  );

  modport slave (
    input  raddr_1, waddr_2, wdata_2, wen_2, addr_3, wdata_3, wen_3,
    input  ks_data, ks_valid,
    output rdata_1, rdata_3, ks_ready
  );

endinterface

// File: rtl/rc4_seq_ctrl_key_sel.sv
// Key byte index counter that wraps at key_len-1, plus the key byte multiplexer.
module rc4_seq_ctrl_key_sel
  import rc4_seq_ctrl_pkg::*;
#(
  parameter int KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [4:0]             key_len,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             key_byte
);

  logic [4:0] kidx;

  // Step through the key one byte per KSA swap, wrapping by compare so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kidx <= 5'd0;
    end else if (clear) begin
      kidx <= 5'd0;
    end else if (advance) begin
      if (kidx == key_len - 5'd1) begin
        kidx <= 5'd0;
      end else begin
        kidx <= kidx + 5'd1;
      end
    end
  end

  // Pick key byte kidx; byte 0 sits in the least significant bits of the key bus.
  always_comb begin
    key_byte = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == 5'(b)) begin
        key_byte = key[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_seq_ctrl.sv
// RC4 phase sequencer: fills the S-box, runs key scheduling, then streams keystream bytes.
module rc4_seq_ctrl
  import rc4_seq_ctrl_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [4:0]             key_len,
  input  logic [LEN_W-1:0]       msg_len,
  output logic                   busy,
  output logic                   err,
  output logic                   done,
  rc4_seq_ctrl_if.master         bus
);

  state_t           state;
  state_t           state_next;
  byte_t            i;
  byte_t            j;
  byte_t            t;
  byte_t            si;
  byte_t            i_inc;
  byte_t            j_ksa;
  byte_t            j_prga;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_next;
  logic [LEN_W-1:0] msg_len_q;
  logic [4:0]       key_len_q;
  logic [7:0]       key_byte;
  logic             done_q;
  logic             err_q;
  logic             start_ok;
  logic             same_ij;
  logic             last_byte;
  logic             init_last;
  logic             sbox_last;

  assign start_ok   = start && key_len_legal(key_len, KEY_BYTES);
  assign i_inc      = i + 8'd1;
  assign j_ksa      = j + bus.rdata_1 + key_byte;
  assign j_prga     = j + bus.rdata_1;
  assign same_ij    = (i == j);
  assign count_next = count + {{(LEN_W-1){1'b0}}, 1'b1};
  assign last_byte  = (count_next == msg_len_q);
  assign init_last  = (i == byte_t'(INIT_CYC - 1));
  assign sbox_last  = (i == byte_t'(SBOX_DEPTH - 1));

  rc4_seq_ctrl_key_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_INIT),
    .advance  (state == ST_KSA_SWP),
    .key_len  (key_len_q),
    .key      (key),
    .key_byte (key_byte)
  );

  // Phase state register; reset drops straight back to IDLE mid-session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Phase sequencing: INIT sweep, three-step KSA per i, five-step PRGA per byte with handshake stall.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_ok) state_next = ST_INIT;
      ST_INIT:    if (init_last) state_next = ST_KSA_RDI;
      ST_KSA_RDI: state_next = ST_KSA_RDJ;
      ST_KSA_RDJ: state_next = ST_KSA_SWP;
      ST_KSA_SWP: begin
        if (!sbox_last) begin
          state_next = ST_KSA_RDI;
        end else if (msg_len_q == '0) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_P_RDI;
        end
      end
      ST_P_RDI:   state_next = ST_P_RDJ;
      ST_P_RDJ:   state_next = ST_P_SWP;
      ST_P_SWP:   state_next = ST_P_RDT;
      ST_P_RDT:   state_next = ST_P_OUT;
      ST_P_OUT: begin
        if (bus.ks_ready) begin
          state_next = last_byte ? ST_IDLE : ST_P_RDI;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Index/temporary registers, session latches and the one-cycle done/err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      j         <= '0;
      t         <= '0;
      si        <= '0;
      count     <= '0;
      msg_len_q <= '0;
      key_len_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              msg_len_q <= msg_len;
              key_len_q <= key_len;
              i         <= '0;
              j         <= '0;
              count     <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          i <= i_inc;
          j <= '0;
        end
        ST_KSA_RDJ: begin
          j  <= j_ksa;
          si <= bus.rdata_1;
        end
        ST_KSA_SWP: begin
          i <= i_inc;
          if (sbox_last) begin
            j <= '0;
            if (msg_len_q == '0) begin
              done_q <= 1'b1;
            end
          end
        end
        ST_P_RDI: begin
          i <= i_inc;
        end
        ST_P_RDJ: begin
          j  <= j_prga;
          si <= bus.rdata_1;
        end
        ST_P_SWP: begin
          t <= si + bus.rdata_3;
        end
        ST_P_OUT: begin
          if (bus.ks_ready) begin
            count <= count_next;
            if (last_byte) begin
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM port muxing per phase; in P_OUT the read address stays on t so the RAM output holds the byte.
  always_comb begin
    busy         = (state != ST_IDLE);
    bus.raddr_1  = '0;
    bus.waddr_2  = '0;
    bus.wdata_2  = '0;
    bus.wen_2    = 1'b0;
    bus.addr_3   = '0;
    bus.wdata_3  = '0;
    bus.wen_3    = 1'b0;
    bus.ks_data  = '0;
    bus.ks_valid = 1'b0;
    case (state)
      ST_INIT: begin
        bus.waddr_2 = i;
        bus.wdata_2 = i;
        bus.wen_2   = 1'b1;
      end
      ST_KSA_RDI: bus.raddr_1 = i;
      ST_KSA_RDJ: bus.addr_3  = j_ksa;
      ST_P_RDI:   bus.raddr_1 = i_inc;
      ST_P_RDJ:   bus.addr_3  = j_prga;
      ST_KSA_SWP, ST_P_SWP: begin
        bus.waddr_2 = i;
        bus.wdata_2 = bus.rdata_3;
        bus.addr_3  = j;
        bus.wdata_3 = si;
        bus.wen_2   = !same_ij;
        bus.wen_3   = !same_ij;
      end
      ST_P_RDT:   bus.raddr_1 = t;
      ST_P_OUT: begin
        bus.raddr_1  = t;
        bus.ks_data  = bus.rdata_1;
        bus.ks_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign err  = err_q;
  assign done = done_q;

endmodule

// File: tb/tb_rc4_seq_ctrl.sv
// Bench for rc4_seq_ctrl: known RC4 vectors, randomized sessions against a software RC4 model.
module tb_rc4_seq_ctrl;

  localparam int KEY_BYTES     = 16;
  localparam int LEN_W         = 16;
  localparam int FIRST_KS_CYC  = 256 + 768 + 5;
  localparam int MSG0_DONE_CYC = 1 + 256 + 768;
  localparam int CYC_LIMIT     = 4000;

  typedef struct {
    logic [127:0] key;
    logic [4:0]   klen;
    logic [15:0]  mlen;
    bit           rand_ready;
    bit           chk_lat;
    bit           poke;
    logic [79:0]  exp;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [8*KEY_BYTES-1:0] key;
  logic [4:0]             key_len;
  logic [LEN_W-1:0]       msg_len;
  logic                   busy;
  logic                   err;
  logic                   done;

  int tests = 0;
  int fails = 0;
  int coll_viol = 0;
  int idle_wen_viol = 0;
  int wen_events = 0;

  logic [7:0] mem [0:255];
  logic [7:0] exp_ks [0:63];
  vec_t       vecs [3];

  rc4_seq_ctrl_if bus();

  rc4_seq_ctrl #(
    .KEY_BYTES (KEY_BYTES),
    .LEN_W     (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .key_len (key_len),
    .msg_len (msg_len),
    .busy    (busy),
    .err     (err),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // S-box RAM with registered, read-before-write outputs.
  always @(posedge clk) begin
    bus.rdata_1 <= mem[bus.raddr_1];
    bus.rdata_3 <= mem[bus.addr_3];
    if (bus.wen_2) mem[bus.waddr_2] <= bus.wdata_2;
    if (bus.wen_3) mem[bus.addr_3] <= bus.wdata_3;
  end

  // Watch for dual-port collisions and writes outside a session.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.wen_2 && bus.wen_3 && bus.waddr_2 == bus.addr_3) coll_viol++;
      if ((bus.wen_2 || bus.wen_3) && !busy) idle_wen_viol++;
      if (bus.wen_2 || bus.wen_3) wen_events++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int val);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected none", name, val);
  endtask

  // Software RC4: key schedule and keystream computed straight from the algorithm.
  task automatic build_ref(input logic [127:0] k, input int klen, input int n);
    int s [0:255];
    int ii;
    int jj;
    int tmp;
    for (int x = 0; x < 256; x++) s[x] = x;
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + s[x] + int'(k[(x % klen)*8 +: 8])) % 256;
      tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
    end
    ii = 0;
    jj = 0;
    for (int m = 0; m < n; m++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      exp_ks[m] = 8'(s[(s[ii] + s[jj]) % 256]);
    end
  endtask

  task automatic fill_from_vec(input int v);
    logic [79:0] e;
    e = vecs[v].exp;
    for (int b = 0; b < 10; b++) exp_ks[b] = e[79-8*b -: 8];
  endtask

  // One full session: start, consume keystream against exp_ks, check done timing.
  task automatic applyStimulus(input string name, input logic [127:0] k, input logic [4:0] klen,
                               input logic [15:0] mlen, input bit rand_ready, input bit chk_lat,
                               input bit poke);
    int  cyc;
    int  idx;
    int  last_acc;
    int  exp_done;
    bit  seen_valid;
    bit  stalled;
    bit  finished;
    bit  rdy;
    logic [7:0] held;
    @(negedge clk);
    key = k;
    key_len = klen;
    msg_len = mlen;
    start = 1'b1;
    bus.ks_ready = 1'b0;
    cyc = 0; idx = 0; last_acc = 0; seen_valid = 0; stalled = 0; finished = 0; held = '0;
    while (!finished && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
      end
      if (poke && cyc == 500) begin
        start = 1'b1;
        msg_len = 16'd1;
      end
      if (poke && cyc == 501) begin
        start = 1'b0;
        msg_len = mlen;
      end
      if (done) begin
        exp_done = (mlen == 0) ? MSG0_DONE_CYC : last_acc + 1;
        checkOutput({name, " done cycle"}, 32'(cyc), 32'(exp_done));
        checkOutput({name, " bytes accepted"}, 32'(idx), 32'(mlen));
        checkOutput({name, " busy with done"}, 32'(busy), 32'd0);
        finished = 1;
      end else if (bus.ks_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          if (chk_lat) checkOutput({name, " first ks_valid cycle"}, 32'(cyc), 32'(FIRST_KS_CYC));
        end
        if (stalled) checkOutput({name, " data held in stall"}, 32'(bus.ks_data), 32'(held));
        rdy = rand_ready ? bit'($urandom_range(0, 1)) : 1'b1;
        bus.ks_ready = rdy;
        if (rdy) begin
          if (idx >= int'(mlen)) begin
            failNow({name, " extra keystream byte"}, idx);
          end else begin
            checkOutput($sformatf("%s byte %0d", name, idx), 32'(bus.ks_data), 32'(exp_ks[idx]));
          end
          idx++;
          last_acc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          held = bus.ks_data;
        end
      end else begin
        bus.ks_ready = 1'b0;
      end
    end
    bus.ks_ready = 1'b0;
    if (!finished) checkOutput({name, " session timeout"}, 32'd1, 32'd0);
  endtask

  // Illegal key length: err pulse, stay idle, no RAM writes.
  task automatic check_reject(input logic [4:0] klen);
    int w0;
    string nm;
    nm = $sformatf("reject klen %0d", klen);
    @(negedge clk);
    key = 128'h79654B;
    key_len = klen;
    msg_len = 16'd5;
    start = 1'b1;
    w0 = wen_events;
    @(negedge clk);
    start = 1'b0;
    checkOutput({nm, " err pulse"}, 32'(err), 32'd1);
    checkOutput({nm, " busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({nm, " err cleared"}, 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput({nm, " ram writes"}, 32'(wen_events - w0), 32'd0);
    checkOutput({nm, " still idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [127:0] rk;
    logic [4:0]   rl;
    logic [15:0]  rm;

    vecs[0] = '{128'h79654B,       5'd3, 16'd10, 1'b0, 1'b0, 1'b1, 80'hEB9F7781B734CA72A719};
    vecs[1] = '{128'h696B6957,     5'd4, 16'd6,  1'b1, 1'b0, 1'b0, 80'h6044DB6D41B700000000};
    vecs[2] = '{128'h746572636553, 5'd6, 16'd8,  1'b0, 1'b1, 1'b0, 80'h04D46B053CA87B590000};

    rst = 1'b1;
    start = 1'b0;
    key = '0;
    key_len = '0;
    msg_len = '0;
    bus.ks_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ram addr/data", {bus.raddr_1, bus.waddr_2, bus.addr_3, bus.wdata_2}, 32'd0);
    checkOutput("reset control outs",
                32'({bus.wdata_3, bus.ks_data, bus.wen_2, bus.wen_3, bus.ks_valid, busy, err, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    check_reject(5'd0);
    check_reject(5'd17);

    for (int v = 0; v < 3; v++) begin
      fill_from_vec(v);
      applyStimulus($sformatf("vec%0d", v), vecs[v].key, vecs[v].klen, vecs[v].mlen,
                    vecs[v].rand_ready, vecs[v].chk_lat, vecs[v].poke);
    end

    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rl = (r == 0) ? 5'd1 : (r == 1) ? 5'd16 : 5'($urandom_range(2, 15));
      rm = 16'($urandom_range(1, 24));
      build_ref(rk, int'(rl), int'(rm));
      applyStimulus($sformatf("rand%0d klen%0d", r, rl), rk, rl, rm, 1'b1, 1'b0, 1'b0);
    end

    applyStimulus("msg_len0", 128'h79654B, 5'd3, 16'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    key = 128'h79654B;
    key_len = 5'd3;
    msg_len = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (599) @(negedge clk);
    checkOutput("mid-KSA busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async reset ram ports", {bus.raddr_1, bus.waddr_2, bus.addr_3, bus.wdata_2}, 32'd0);
    checkOutput("async reset controls", 32'({bus.wen_2, bus.wen_3, bus.ks_valid, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_from_vec(0);
    applyStimulus("after reset", 128'h79654B, 5'd3, 16'd10, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("dual-port collisions", 32'(coll_viol), 32'd0);
    checkOutput("writes outside session", 32'(idle_wen_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
